// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths, opcode encodings, entry/payload types and CDB snoop helper.
package alu_rs_pkg;
    localparam int ROB_R = 4;
    localparam int RS_SIZE_DEF = 8;
    // {funct7[5], funct3, opcode}
    localparam logic [10:0] OP_ADDI = {1'b0, 3'b000, 7'b0010011};
    localparam logic [10:0] OP_ADD  = {1'b0, 3'b000, 7'b0110011};

    typedef struct packed {
        logic             busy;
        logic [10:0]      op;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [ROB_R-1:0] rob_id;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic             q1_has;
        logic [ROB_R-1:0] q1;
        logic             q2_has;
        logic [ROB_R-1:0] q2;
    } rs_entry_t;

    typedef struct packed {
        logic [10:0]      op;
        logic [31:0]      v1;
        logic [31:0]      v2;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [ROB_R-1:0] rob_id;
    } alu_pay_t;

    typedef struct packed {
        logic        has;
        logic [31:0] val;
    } opnd_t;

    // Resolve a pending operand against both result buses; the ALU bus wins a tie.
    function automatic opnd_t snoop(
        input opnd_t            o,
        input logic [ROB_R-1:0] tag,
        input logic             a_v,
        input logic [ROB_R-1:0] a_id,
        input logic [31:0]      a_val,
        input logic             l_v,
        input logic [ROB_R-1:0] l_id,
        input logic [31:0]      l_val
    );
        snoop = o;
        if (o.has && a_v && tag == a_id)
            snoop = {1'b0, a_val};
        else if (o.has && l_v && tag == l_id)
            snoop = {1'b0, l_val};
    endfunction
endpackage

// File: rtl/rs_pick.sv
// rs_pick: lowest-index priority encoder.
//   req   : request vector
//   idx   : index of lowest set bit (0 when none)
//   found : any bit set
module rs_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) begin
                idx = W'(i);
                found = 1'b1;
            end
    end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup and in-order-by-index dispatch.
//   clk_in/rst_in(sync, active-low)/rdy_in(freeze)/clear_in(flush)
//   iss_*   : one instruction issued per cycle; full blocks issue
//   cdb_*   : ALU and load-store result broadcasts
//   alu_*   : registered dispatch strobe and payload
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int RS_IDX_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear_in,
    input  logic             iss_valid,
    input  logic [10:0]      iss_op,
    input  logic [31:0]      iss_pc,
    input  logic [31:0]      iss_imm,
    input  logic [ROB_R-1:0] iss_rob_id,
    input  logic             iss_q1_has,
    input  logic             iss_q2_has,
    input  logic [ROB_R-1:0] iss_q1,
    input  logic [ROB_R-1:0] iss_q2,
    input  logic [31:0]      iss_v1,
    input  logic [31:0]      iss_v2,
    output logic             full,
    input  logic             cdb_alu_valid,
    input  logic [ROB_R-1:0] cdb_alu_rob_id,
    input  logic [31:0]      cdb_alu_value,
    input  logic             cdb_lsb_valid,
    input  logic [ROB_R-1:0] cdb_lsb_rob_id,
    input  logic [31:0]      cdb_lsb_value,
    output logic             alu_yes,
    output logic [10:0]      alu_op,
    output logic [31:0]      alu_v1,
    output logic [31:0]      alu_v2,
    output logic [31:0]      alu_pc,
    output logic [31:0]      alu_imm,
    output logic [ROB_R-1:0] alu_rob_id
);
    rs_entry_t ent_q [RS_SIZE];
    rs_entry_t ent_d [RS_SIZE];
    alu_pay_t pay_q, pay_d;
    logic alu_yes_q, alu_yes_d;
    logic [RS_SIZE-1:0] busy, ready;
    logic [RS_IDX_W-1:0] free_idx, rdy_idx;
    logic free_found, rdy_found;

    always_comb begin
        busy = '0;
        ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy[i] = ent_q[i].busy;
            ready[i] = ent_q[i].busy && !ent_q[i].q1_has && !ent_q[i].q2_has;
        end
    end

    rs_pick #(.N(RS_SIZE), .W(RS_IDX_W)) u_free (.req(~busy), .idx(free_idx), .found(free_found));
    rs_pick #(.N(RS_SIZE), .W(RS_IDX_W)) u_rdy  (.req(ready), .idx(rdy_idx),  .found(rdy_found));

    assign full = &busy;

    always_comb begin
        ent_d = ent_q;
        pay_d = pay_q;
        alu_yes_d = 1'b0;
        if (clear_in) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent_d[i].busy = 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++)
                if (ent_q[i].busy) begin
                    {ent_d[i].q1_has, ent_d[i].v1} = snoop({ent_q[i].q1_has, ent_q[i].v1}, ent_q[i].q1,
                        cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
                    {ent_d[i].q2_has, ent_d[i].v2} = snoop({ent_q[i].q2_has, ent_q[i].v2}, ent_q[i].q2,
                        cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
                end
            if (rdy_found) begin
                alu_yes_d = 1'b1;
                pay_d = '{op: ent_q[rdy_idx].op, v1: ent_q[rdy_idx].v1, v2: ent_q[rdy_idx].v2,
                          pc: ent_q[rdy_idx].pc, imm: ent_q[rdy_idx].imm, rob_id: ent_q[rdy_idx].rob_id};
                ent_d[rdy_idx].busy = 1'b0;
            end
            // free_idx comes from registered busy, so a slot vacated by this edge's dispatch is never reused
            if (iss_valid && free_found) begin
                ent_d[free_idx] = '{busy: 1'b1, op: iss_op, pc: iss_pc, imm: iss_imm, rob_id: iss_rob_id,
                                    v1: iss_v1, v2: iss_v2, q1_has: iss_q1_has, q1: iss_q1,
                                    q2_has: iss_q2_has, q2: iss_q2};
                {ent_d[free_idx].q1_has, ent_d[free_idx].v1} = snoop({iss_q1_has, iss_v1}, iss_q1,
                    cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
                {ent_d[free_idx].q2_has, ent_d[free_idx].v2} = snoop({iss_q2_has, iss_v2}, iss_q2,
                    cdb_alu_valid, cdb_alu_rob_id, cdb_alu_value, cdb_lsb_valid, cdb_lsb_rob_id, cdb_lsb_value);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++)
                ent_q[i] <= '0;
            pay_q <= '0;
            alu_yes_q <= 1'b0;
        end else begin
            ent_q <= ent_d;
            pay_q <= pay_d;
            alu_yes_q <= alu_yes_d;
        end
    end

    assign alu_yes = alu_yes_q;
    assign alu_op = pay_q.op;
    assign alu_v1 = pay_q.v1;
    assign alu_v2 = pay_q.v2;
    assign alu_pc = pay_q.pc;
    assign alu_imm = pay_q.imm;
    assign alu_rob_id = pay_q.rob_id;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed vector table, fill/full sequence and randomized run against a slot-level model.
module tb_alu_rs;
    import alu_rs_pkg::*;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst, rdy, clr, iv, h1, h2, av, lv;
    logic [10:0] op;
    logic [31:0] pc, imm, v1, v2, aval, lval;
    logic [ROB_R-1:0] rob, q1, q2, aid, lid;
    logic full, alu_yes;
    logic [10:0] alu_op;
    logic [31:0] alu_v1, alu_v2, alu_pc, alu_imm;
    logic [ROB_R-1:0] alu_rob_id;

    always #5 clk = ~clk;

    alu_rs dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
        .iss_valid(iv), .iss_op(op), .iss_pc(pc), .iss_imm(imm), .iss_rob_id(rob),
        .iss_q1_has(h1), .iss_q2_has(h2), .iss_q1(q1), .iss_q2(q2), .iss_v1(v1), .iss_v2(v2),
        .full(full),
        .cdb_alu_valid(av), .cdb_alu_rob_id(aid), .cdb_alu_value(aval),
        .cdb_lsb_valid(lv), .cdb_lsb_rob_id(lid), .cdb_lsb_value(lval),
        .alu_yes(alu_yes), .alu_op(alu_op), .alu_v1(alu_v1), .alu_v2(alu_v2),
        .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_rob_id(alu_rob_id)
    );

    typedef struct {
        logic rst, rdy, clr, iv, h1, h2, av, lv;
        logic [10:0] op;
        logic [31:0] pc, imm, v1, v2, aval, lval;
        logic [ROB_R-1:0] rob, q1, q2, aid, lid;
    } in_t;

    typedef struct {
        in_t i;
        logic ey;
        logic [31:0] ev1, ev2;
        logic [ROB_R-1:0] erob;
    } vec_t;

    typedef struct {
        logic b, h1, h2;
        logic [10:0] op;
        logic [31:0] pc, imm, v1, v2;
        logic [ROB_R-1:0] rob, q1, q2;
    } m_t;

    m_t m [N];
    logic e_yes, e_full;
    logic [142:0] e_pay;
    int n_pass = 0, n_tot = 0;

    function automatic in_t idle();
        in_t x = '{default: '0};
        x.rst = 1'b1;
        x.rdy = 1'b1;
        x.op = OP_ADD;
        return x;
    endfunction

    function automatic in_t iss(logic [ROB_R-1:0] r, logic p1, logic [ROB_R-1:0] t1, logic [31:0] a, logic [31:0] b);
        in_t x = idle();
        x.iv = 1'b1;
        x.op = p1 ? OP_ADD : OP_ADDI;
        x.rob = r;
        x.pc = 32'h1000 + {28'd0, r};
        x.h1 = p1;
        x.q1 = t1;
        x.v1 = a;
        x.v2 = b;
        x.imm = b;
        return x;
    endfunction

    function automatic in_t bc(in_t x, logic a_v, logic [ROB_R-1:0] a_id, logic [31:0] a_val,
                               logic l_v, logic [ROB_R-1:0] l_id, logic [31:0] l_val);
        x.av = a_v; x.aid = a_id; x.aval = a_val;
        x.lv = l_v; x.lid = l_id; x.lval = l_val;
        return x;
    endfunction

    function automatic vec_t vc(in_t x, logic y, logic [31:0] a, logic [31:0] b, logic [ROB_R-1:0] r);
        vec_t v;
        v.i = x; v.ey = y; v.ev1 = a; v.ev2 = b; v.erob = r;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Operand resolution from the bus rules: ALU bus checked first, then load-store bus.
    function automatic logic [32:0] res(in_t x, logic h, logic [ROB_R-1:0] t, logic [31:0] v);
        if (h && x.av && x.aid == t) return {1'b0, x.aval};
        if (h && x.lv && x.lid == t) return {1'b0, x.lval};
        return {h, v};
    endfunction

    task automatic model_step(input in_t x);
        int cnt, r, f;
        if (!x.rst) begin
            foreach (m[i]) m[i].b = 1'b0;
            e_yes = 1'b0;
            e_pay = '0;
        end else if (x.clr) begin
            foreach (m[i]) m[i].b = 1'b0;
            e_yes = 1'b0;
        end else if (!x.rdy) begin
            e_yes = 1'b0;
        end else begin
            cnt = 0; r = -1; f = -1;
            foreach (m[i]) begin
                if (m[i].b) cnt++;
                if (r < 0 && m[i].b && !m[i].h1 && !m[i].h2) r = i;
                if (f < 0 && !m[i].b) f = i;
            end
            foreach (m[i])
                if (m[i].b) begin
                    {m[i].h1, m[i].v1} = res(x, m[i].h1, m[i].q1, m[i].v1);
                    {m[i].h2, m[i].v2} = res(x, m[i].h2, m[i].q2, m[i].v2);
                end
            e_yes = r >= 0;
            if (r >= 0) begin
                e_pay = {m[r].op, m[r].v1, m[r].v2, m[r].pc, m[r].imm, m[r].rob};
                m[r].b = 1'b0;
            end
            if (x.iv && cnt < N) begin
                m[f].b = 1'b1; m[f].op = x.op; m[f].pc = x.pc; m[f].imm = x.imm; m[f].rob = x.rob;
                m[f].q1 = x.q1; m[f].q2 = x.q2;
                {m[f].h1, m[f].v1} = res(x, x.h1, x.q1, x.v1);
                {m[f].h2, m[f].v2} = res(x, x.h2, x.q2, x.v2);
            end
        end
        cnt = 0;
        foreach (m[i]) if (m[i].b) cnt++;
        e_full = cnt == N;
    endtask

    task automatic apply(input in_t x);
        rst = x.rst; rdy = x.rdy; clr = x.clr; iv = x.iv; op = x.op; pc = x.pc; imm = x.imm;
        rob = x.rob; h1 = x.h1; q1 = x.q1; v1 = x.v1; h2 = x.h2; q2 = x.q2; v2 = x.v2;
        av = x.av; aid = x.aid; aval = x.aval; lv = x.lv; lid = x.lid; lval = x.lval;
        model_step(x);
        @(posedge clk);
        #1;
        chk("model_alu_yes", {159'd0, alu_yes}, {159'd0, e_yes});
        chk("model_full", {159'd0, full}, {159'd0, e_full});
        chk("model_payload", {17'd0, alu_op, alu_v1, alu_v2, alu_pc, alu_imm, alu_rob_id}, {17'd0, e_pay});
    endtask

    vec_t tbl [26];

    initial begin
        in_t x;
        foreach (m[i]) m[i] = '{default: '0};
        e_yes = 1'b0; e_full = 1'b0; e_pay = '0;

        x = idle();
        x.rst = 1'b0;
        apply(x);
        apply(x);
        chk("reset_yes", {159'd0, alu_yes}, 160'd0);
        chk("reset_full", {159'd0, full}, 160'd0);
        chk("reset_rob", {156'd0, alu_rob_id}, 160'd0);

        tbl[0]  = vc(iss(2, 0, 0, 5, 3), 0, 0, 0, 0);
        tbl[1]  = vc(idle(), 1, 5, 3, 2);
        tbl[2]  = vc(idle(), 0, 0, 0, 0);
        tbl[3]  = vc(iss(5, 1, 4, 0, 7), 0, 0, 0, 0);
        tbl[4]  = vc(idle(), 0, 0, 0, 0);
        tbl[5]  = vc(bc(idle(), 1, 4, 10, 0, 0, 0), 0, 0, 0, 0);
        tbl[6]  = vc(idle(), 1, 10, 7, 5);
        tbl[7]  = vc(bc(iss(6, 1, 3, 0, 1), 0, 0, 0, 1, 3, 32'hFFFF_FFFF), 0, 0, 0, 0);
        tbl[8]  = vc(idle(), 1, 32'hFFFF_FFFF, 1, 6);
        tbl[9]  = vc(iss(7, 1, 8, 0, 2), 0, 0, 0, 0);
        tbl[10] = vc(iss(8, 1, 9, 0, 2), 0, 0, 0, 0);
        x = idle(); x.clr = 1'b1;
        tbl[11] = vc(x, 0, 0, 0, 0);
        tbl[12] = vc(bc(idle(), 1, 8, 1, 1, 9, 2), 0, 0, 0, 0);
        tbl[13] = vc(idle(), 0, 0, 0, 0);
        tbl[14] = vc(iss(1, 1, 10, 0, 9), 0, 0, 0, 0);
        tbl[15] = vc(iss(3, 1, 11, 0, 32'h11), 0, 0, 0, 0);
        tbl[16] = vc(iss(4, 1, 10, 0, 9), 0, 0, 0, 0);
        tbl[17] = vc(iss(9, 1, 10, 0, 9), 0, 0, 0, 0);
        tbl[18] = vc(iss(10, 1, 10, 0, 9), 0, 0, 0, 0);
        tbl[19] = vc(iss(12, 1, 11, 0, 32'h55), 0, 0, 0, 0);
        tbl[20] = vc(bc(idle(), 1, 11, 32'h77, 0, 0, 0), 0, 0, 0, 0);
        tbl[21] = vc(idle(), 1, 32'h77, 32'h11, 3);
        x = idle(); x.rdy = 1'b0;
        tbl[22] = vc(x, 0, 0, 0, 0);
        tbl[23] = vc(idle(), 1, 32'h77, 32'h55, 12);
        tbl[24] = vc(idle(), 0, 0, 0, 0);
        x = idle(); x.clr = 1'b1;
        tbl[25] = vc(x, 0, 0, 0, 0);

        for (int k = 0; k < 26; k++) begin
            apply(tbl[k].i);
            chk($sformatf("tbl%0d_yes", k), {159'd0, alu_yes}, {159'd0, tbl[k].ey});
            chk($sformatf("tbl%0d_full", k), {159'd0, full}, 160'd0);
            if (tbl[k].ey) begin
                chk($sformatf("tbl%0d_v1", k), {128'd0, alu_v1}, {128'd0, tbl[k].ev1});
                chk($sformatf("tbl%0d_v2", k), {128'd0, alu_v2}, {128'd0, tbl[k].ev2});
                chk($sformatf("tbl%0d_imm", k), {128'd0, alu_imm}, {128'd0, tbl[k].ev2});
                chk($sformatf("tbl%0d_rob", k), {156'd0, alu_rob_id}, {156'd0, tbl[k].erob});
            end
        end

        for (int i = 0; i < N; i++)
            apply(iss(ROB_R'(8 + i), 1, ROB_R'(i), 0, i));
        chk("fill_full", {159'd0, full}, 160'd1);
        apply(iss(15, 0, 0, 1, 2));
        chk("ignored_yes", {159'd0, alu_yes}, 160'd0);
        chk("ignored_full", {159'd0, full}, 160'd1);
        apply(bc(idle(), 1, 3, 32'h33, 0, 0, 0));
        chk("wake_full", {159'd0, full}, 160'd1);
        apply(idle());
        chk("wake_yes", {159'd0, alu_yes}, 160'd1);
        chk("wake_rob", {156'd0, alu_rob_id}, 160'd11);
        chk("wake_v1", {128'd0, alu_v1}, 160'h33);
        chk("wake_full_clr", {159'd0, full}, 160'd0);
        apply(idle());
        chk("ignored_not_stored", {159'd0, alu_yes}, 160'd0);
        x = idle(); x.clr = 1'b1;
        apply(x);

        apply(iss(1, 0, 0, 4, 4));
        x = idle(); x.rst = 1'b0; x.clr = 1'b1; x.rdy = 1'b0;
        apply(x);
        apply(idle());
        chk("rst_discard_yes", {159'd0, alu_yes}, 160'd0);

        for (int c = 0; c < 1500; c++) begin
            x = idle();
            x.rst = $urandom_range(0, 63) != 0;
            x.clr = $urandom_range(0, 31) == 0;
            x.rdy = $urandom_range(0, 7) != 0;
            x.iv = $urandom_range(0, 1) == 1;
            x.op = 11'($urandom);
            x.pc = $urandom; x.imm = $urandom; x.v1 = $urandom; x.v2 = $urandom;
            x.rob = ROB_R'($urandom);
            x.h1 = $urandom_range(0, 1) == 1; x.q1 = ROB_R'($urandom_range(0, 3));
            x.h2 = $urandom_range(0, 2) == 0; x.q2 = ROB_R'($urandom_range(0, 3));
            x.av = $urandom_range(0, 2) == 0; x.aid = ROB_R'($urandom_range(0, 3)); x.aval = $urandom;
            x.lv = $urandom_range(0, 2) == 0; x.lid = ROB_R'($urandom_range(0, 3)); x.lval = $urandom;
            apply(x);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
